addsub16_accum: RTL

- 16-bit registered accumulator. It sits directly downstream of the 16-bit ripple adder (FA16) in the adder-subtractor datapath.
- Each accepted operand is added to, subtracted from, loaded into, or clears the accumulator. The adder is instantiated internally with A = accumulator.
- The result and status flags are presented through a one-entry valid/ready output register.

---
 rtl/addsub16_accum.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/addsub16_accum.sv
// 16-bit add/sub/load/clear accumulator behind a one-entry valid/ready result register.
// Optional clamp-on-overflow build: define ADDSUB16_SATURATE_EN.

module fa16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic [W-1:0] S,
    output logic         Co
);
    logic [W:0] c_s;

    assign c_s[0] = Ci;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign S[i]     = A[i] ^ B[i] ^ c_s[i];
            assign c_s[i+1] = (A[i] & B[i]) | (c_s[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Co = c_s[W];
endmodule

module addsub16_accum #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         Co,
    output logic         V,
    output logic         Z,
    output logic         N,
    output logic         V_sticky
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t       state_r;
    logic [W-1:0] acc_r;
    logic         co_r;
    logic         v_r;
    logic         z_r;
    logic         n_r;
    logic         v_sticky_r;

    logic         accept_s;
    logic [W-1:0] b_eff_s;
    logic         cin_s;
    logic [W-1:0] sum_s;
    logic         carry_s;
    logic         ovf_s;
    logic [W-1:0] acc_next_s;
    logic         co_next_s;
    logic         v_next_s;
    logic         v_sticky_next_s;

    assign in_ready = (state_r == EMPTY) || out_ready;
    assign accept_s = in_valid && in_ready;

    // Subtraction reuses the adder as acc + ~B + 1.
    assign b_eff_s = (op == OP_SUB) ? ~B : B;
    assign cin_s   = (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? Ci : 1'b0);

    fa16 #(.W(W)) u_fa16 (
        .A  (acc_r),
        .B  (b_eff_s),
        .Ci (cin_s),
        .S  (sum_s),
        .Co (carry_s)
    );

    // Overflow: like-signed adder inputs producing an opposite-signed sum.
    assign ovf_s = (acc_r[W-1] == b_eff_s[W-1]) && (sum_s[W-1] != acc_r[W-1]);

    // Next accumulator value and status flags for the presented operation.
    always_comb begin
        acc_next_s      = acc_r;
        co_next_s       = 1'b0;
        v_next_s        = 1'b0;
        v_sticky_next_s = v_sticky_r;
        case (op)
            OP_ADD, OP_SUB: begin
                acc_next_s      = sum_s;
                co_next_s       = carry_s;
                v_next_s        = ovf_s;
                v_sticky_next_s = v_sticky_r | ovf_s;
`ifdef ADDSUB16_SATURATE_EN
                if (ovf_s) begin
                    acc_next_s = acc_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                end else begin
                    acc_next_s = sum_s;
                end
`endif
            end
            OP_LOAD: begin
                acc_next_s = B;
            end
            OP_CLEAR: begin
                acc_next_s      = {W{1'b0}};
                v_sticky_next_s = 1'b0;
            end
            default: begin
                acc_next_s = acc_r;
            end
        endcase
    end

    // Result register and EMPTY/FULL state; holds everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= EMPTY;
            acc_r      <= {W{1'b0}};
            co_r       <= 1'b0;
            v_r        <= 1'b0;
            z_r        <= 1'b1;
            n_r        <= 1'b0;
            v_sticky_r <= 1'b0;
        end else begin
            if (accept_s) begin
                state_r    <= FULL;
                acc_r      <= acc_next_s;
                co_r       <= co_next_s;
                v_r        <= v_next_s;
                z_r        <= (acc_next_s == {W{1'b0}});
                n_r        <= acc_next_s[W-1];
                v_sticky_r <= v_sticky_next_s;
            end else if ((state_r == FULL) && out_ready) begin
                state_r <= EMPTY;
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign out_valid = (state_r == FULL);
    assign S         = acc_r;
    assign Co        = co_r;
    assign V         = v_r;
    assign Z         = z_r;
    assign N         = n_r;
    assign V_sticky  = v_sticky_r;
endmodule
